// File: rtl/tap_route.sv
// IEEE 1149.1-style TAP controller presenting a fixed IDCODE or BYPASS on TDO_Pad.
// Define TAP_ROUTE_TMS_PULSE_EN to treat TMS_Pad as a return-to-zero pulse input.
`timescale 1ns/1ps
module tap_route (
  input  logic GCLK_Pad,
  input  logic RSTN_Pad,
  input  logic TMS_Pad,
  output logic TDO_Pad
);

  localparam logic [31:0] IDCODE     = 32'h1ABC_D001;
  localparam logic [3:0]  IR_CAPTURE = 4'b0001;
  localparam logic [3:0]  IR_IDCODE  = 4'b0001;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } state_t;

  state_t      state, next_state;
  logic        tms;
  logic [3:0]  ir, ir_shift;
  logic [31:0] dr_shift;
  logic        bypass;
  logic        tdo_next;

`ifdef TAP_ROUTE_TMS_PULSE_EN
  // Each pulse flips tms_toggle; a change since the last GCLK edge reads as TMS=1.
  logic tms_toggle, tms_seen;

  always_ff @(posedge TMS_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) tms_toggle <= 1'b0;
    else           tms_toggle <= ~tms_toggle;
  end

  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) tms_seen <= 1'b0;
    else           tms_seen <= tms_toggle;
  end

  assign tms = tms_toggle ^ tms_seen;
`else
  assign tms = TMS_Pad;
`endif

  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) state <= TLR;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = tms ? TLR      : RTI;
      RTI:      next_state = tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next_state = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next_state = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next_state = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   next_state = tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next_state = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next_state = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next_state = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   next_state = tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // TDO carries data only while staying in a shift state; it drops on the leaving edge.
  always_comb begin
    tdo_next = 1'b0;
    if (state == SHIFT_DR && !tms)
      tdo_next = (ir == IR_IDCODE) ? dr_shift[0] : bypass;
    else if (state == SHIFT_IR && !tms)
      tdo_next = ir_shift[0];
  end

  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) begin
      ir       <= IR_IDCODE;
      ir_shift <= 4'b0000;
      dr_shift <= 32'h0;
      bypass   <= 1'b0;
      TDO_Pad  <= 1'b0;
    end else begin
      TDO_Pad <= tdo_next;
      case (state)
        TLR:      ir       <= IR_IDCODE;
        CAP_IR:   ir_shift <= IR_CAPTURE;
        SHIFT_IR: ir_shift <= {1'b0, ir_shift[3:1]};
        UPD_IR:   ir       <= ir_shift;
        CAP_DR: begin
          if (ir == IR_IDCODE) dr_shift <= IDCODE;
          else                 bypass   <= 1'b0;
        end
        SHIFT_DR: begin
          if (ir == IR_IDCODE) dr_shift <= {1'b0, dr_shift[31:1]};
          else                 bypass   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_route.sv
// Self-checking bench for tap_route: directed vector table, mid-shift reset, and
// randomized TMS checked against a table-driven TAP reference model.
`timescale 1ns/1ps
module tb_tap_route;

  localparam logic [31:0] IDCODE = 32'h1ABC_D001;

  // Model state numbering: capture..update of each xR path are six consecutive ids.
  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4;
  localparam int SIR = 9, CIR = 10, SHIR = 11, UIR = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic tms_pad;
  logic tdo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit tms;
    bit tdo;
  } vec_t;
  vec_t vecs[$];

  int       nxt0[16];
  int       nxt1[16];
  int       m_state;
  bit [3:0] m_ir, m_irs;
  bit [31:0] m_dr;
  bit       m_byp;

  always #5 clk = ~clk;

  tap_route dut (
    .GCLK_Pad(clk),
    .RSTN_Pad(rst_n),
    .TMS_Pad (tms_pad),
    .TDO_Pad (tdo)
  );

  function automatic void build_model_table();
    nxt0[TLR] = RTI; nxt1[TLR] = TLR;
    nxt0[RTI] = RTI; nxt1[RTI] = SDR;
    nxt0[SDR] = CDR; nxt1[SDR] = SIR;
    nxt0[SIR] = CIR; nxt1[SIR] = TLR;
    foreach (nxt0[k]) if (k == CDR || k == CIR) begin
      nxt0[k]   = k + 1; nxt1[k]   = k + 2;
      nxt0[k+1] = k + 1; nxt1[k+1] = k + 2;
      nxt0[k+2] = k + 3; nxt1[k+2] = k + 5;
      nxt0[k+3] = k + 3; nxt1[k+3] = k + 4;
      nxt0[k+4] = k + 1; nxt1[k+4] = k + 5;
      nxt0[k+5] = RTI;   nxt1[k+5] = SDR;
    end
  endfunction

  function automatic void model_reset();
    m_state = TLR;
    m_ir    = 4'b0001;
    m_irs   = 4'b0000;
    m_dr    = 32'h0;
    m_byp   = 1'b0;
  endfunction

  // Advances the model by one TCK edge and returns the TDO value expected after it.
  function automatic bit model_step(bit t);
    bit e = 1'b0;
    if (!t && m_state == SHDR) e = (m_ir == 4'b0001) ? m_dr[0] : m_byp;
    if (!t && m_state == SHIR) e = m_irs[0];
    if (m_state == TLR)  m_ir  = 4'b0001;
    if (m_state == CIR)  m_irs = 4'b0001;
    if (m_state == SHIR) m_irs = m_irs / 2;
    if (m_state == UIR)  m_ir  = m_irs;
    if (m_state == CDR) begin
      if (m_ir == 4'b0001) m_dr = IDCODE; else m_byp = 1'b0;
    end
    if (m_state == SHDR) begin
      if (m_ir == 4'b0001) m_dr = m_dr / 2; else m_byp = 1'b0;
    end
    m_state = t ? nxt1[m_state] : nxt0[m_state];
    return e;
  endfunction

  function automatic void add(bit t, bit e);
    vecs.push_back('{tms: t, tdo: e});
  endfunction

  function automatic void add_idcode_readout();
    add(1'b1, 1'b0); add(1'b0, 1'b0); add(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) add(1'b0, IDCODE[i]);
  endfunction

  task automatic drive_tms(input bit t);
    @(negedge clk);
`ifdef TAP_ROUTE_TMS_PULSE_EN
    tms_pad = 1'b0;
    if (t) begin
      #1 tms_pad = 1'b1;
      #0.002 tms_pad = 1'b0;
    end
`else
    tms_pad = t;
`endif
  endtask

  task automatic apply_stimulus(input bit t, output bit e);
    drive_tms(t);
    e = model_step(t);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input bit exp);
    checks++;
    if (tdo !== exp) begin
      errors++;
      $display("[TB] FAIL %s: tdo=%b expected=%b", name, tdo, exp);
    end
  endtask

  // Asserts reset mid-period, checks TDO clears at once, then releases with TMS low.
  task automatic do_reset(input string name);
    bit e;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_output({name, "_async"}, 1'b0);
    model_reset();
    @(posedge clk);
    #1 check_output({name, "_held"}, 1'b0);
    @(negedge clk);
    tms_pad = 1'b0;
    rst_n   = 1'b1;
    e = model_step(1'b0);
    @(posedge clk);
    #1 check_output({name, "_release"}, e);
  endtask

  initial begin
    bit        e;
    bit        seq_b[11];
    bit [31:0] got;

    build_model_table();
    model_reset();
    rst_n   = 1'b0;
    tms_pad = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_output("reset_state", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (20) add(1'b0, 1'b0);
    seq_b = '{1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    foreach (seq_b[i]) add(seq_b[i], 1'b0);
    add_idcode_readout();
    add(1'b0, 1'b0); add(1'b0, 1'b0);
    add(1'b1, 1'b0); add(1'b1, 1'b0); add(1'b0, 1'b0);
    add(1'b1, 1'b0); add(1'b1, 1'b0); add(1'b0, 1'b0); add(1'b0, 1'b0);
    add(1'b0, 1'b1); add(1'b0, 1'b0); add(1'b0, 1'b0); add(1'b0, 1'b0);
    add(1'b1, 1'b0); add(1'b1, 1'b0); add(1'b0, 1'b0);
    add(1'b1, 1'b0); add(1'b0, 1'b0); add(1'b0, 1'b0);
    add(1'b0, 1'b0); add(1'b0, 1'b0); add(1'b0, 1'b0);
    add(1'b1, 1'b0); add(1'b1, 1'b0); add(1'b0, 1'b0);
    // Leave a partially shifted IR in Pause-IR, then five TMS=1 edges must restore IDCODE.
    add(1'b1, 1'b0); add(1'b1, 1'b0); add(1'b0, 1'b0); add(1'b0, 1'b0);
    add(1'b0, 1'b1); add(1'b1, 1'b0); add(1'b0, 1'b0);
    repeat (5) add(1'b1, 1'b0);
    add(1'b0, 1'b0);
    add_idcode_readout();
    add(1'b1, 1'b0); add(1'b1, 1'b0); add(1'b0, 1'b0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].tms, e);
      check_output($sformatf("vec%0d", i), vecs[i].tdo);
    end

    apply_stimulus(1'b1, e); apply_stimulus(1'b0, e);
    apply_stimulus(1'b0, e); apply_stimulus(1'b0, e);
    check_output("pre_reset_bit0", 1'b1);
    do_reset("mid_shift_reset");

    got = 32'h0;
    apply_stimulus(1'b1, e); check_output("rescan_sel", e);
    apply_stimulus(1'b0, e); check_output("rescan_cap", e);
    apply_stimulus(1'b0, e); check_output("rescan_enter", e);
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b0, e);
      check_output($sformatf("rescan_bit%0d", i), e);
      got[i] = tdo;
    end
    checks++;
    if (got !== IDCODE) begin
      errors++;
      $display("[TB] FAIL rescan_word: got=%h expected=%h", got, IDCODE);
    end

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($sformatf("rand_reset%0d", n));
      end else begin
        apply_stimulus($urandom_range(0, 99) < 30, e);
        check_output($sformatf("rand%0d", n), e);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
